// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, parallel load, logical/arithmetic shift, rotate and clear,
// with a programmable synchronous reset value and serial in/out at both ends.
module universal_shift_reg #(
    parameter int unsigned          WIDTH   = 8,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic             SIN_L,
    input  logic             SIN_R,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             SOUT_MSB,
    output logic             SOUT_LSB,
    output logic             ZERO
);

    localparam logic [2:0] ModeHold = 3'd0;
    localparam logic [2:0] ModeLoad = 3'd1;
    localparam logic [2:0] ModeShl  = 3'd2;
    localparam logic [2:0] ModeShr  = 3'd3;
    localparam logic [2:0] ModeRol  = 3'd4;
    localparam logic [2:0] ModeRor  = 3'd5;
    localparam logic [2:0] ModeAsr  = 3'd6;
    localparam logic [2:0] ModeClr  = 3'd7;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             zero_q;
    logic             zero_d;

    always_comb begin
        q_d = q_q;
        if (EN) begin
            case (MODE)
                ModeHold: q_d = q_q;
                ModeLoad: q_d = D;
                ModeShl:  q_d = {q_q[WIDTH-2:0], SIN_R};
                ModeShr:  q_d = {SIN_L, q_q[WIDTH-1:1]};
                ModeRol:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                ModeRor:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                ModeAsr:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                ModeClr:  q_d = '0;
                default:  q_d = q_q;
            endcase
        end
        // Flag derived from next-state so it changes on the same edge as Q.
        zero_d = (q_d == '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q    <= RST_VAL;
            zero_q <= (RST_VAL == '0);
        end else begin
            q_q    <= q_d;
            zero_q <= zero_d;
        end
    end

    assign Q        = q_q;
    assign ZERO     = zero_q;
    assign SOUT_MSB = q_q[WIDTH-1];
    assign SOUT_LSB = q_q[0];

endmodule
